// File: rtl/mem_responder_pkg.sv
// Shared encodings and defaults for the multi-cycle memory responder.
package mem_responder_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Captured memory operation.
  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } mem_op_e;

  // Default edges from request acceptance to the Done cycle.
  localparam int unsigned DefaultLatency = 2;

  // Latency counter width; covers LATENCY-1 up to 14.
  localparam int unsigned CntW = 4;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port 16-bit RAM with registered read data and no reset.
module mem_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [2**ADDR_W];
  logic [15:0] rdata_q;

  // Write on we; read-first registered data every edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: accepts one word request at a time, stalls
// the requester for LATENCY-1 cycles and pulses Done with read data.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = DefaultLatency,
  parameter bit          ALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Err
);

  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              err_q, err_d;

  logic              misalign;
  logic              req_valid;
  logic              req_reject;
  logic              mem_we;
  logic [15:0]       mem_rdata;
  logic              unused_addr;

  // Upper address bits beyond the array simply alias.
  assign unused_addr = ^Addr;

  assign misalign   = ALIGN_CHK && Addr[0];
  assign req_valid  = (Rd ^ Wr) && !misalign;
  assign req_reject = (Rd && Wr) || ((Rd || Wr) && misalign);

  // Next-state: request acceptance, latency countdown and reject pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (req_valid) begin
          op_d    = Wr ? OpWr : OpRd;
          addr_d  = Addr[ADDR_W:1];
          data_d  = DataIn;
          cnt_d   = CntLoad;
          state_d = (LATENCY > 1) ? StBusy : StDone;
        end else if (req_reject) begin
          err_d = 1'b1;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and capture registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpRd;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // The array is driven with next-state capture values so that LATENCY=1
  // commits/reads on the acceptance edge; state_d==StDone only on DONE entry.
  assign mem_we = (state_d == StDone) && (op_d == OpWr);

  mem_array #(
    .ADDR_W(ADDR_W)
  ) u_mem_array (
    .clk_i  (clk),
    .we_i   (mem_we),
    .addr_i (addr_d),
    .wdata_i(data_d),
    .rdata_o(mem_rdata)
  );

  // Gate the unreset RAM register so outputs read zero out of reset.
  assign DataOut = ((state_q == StDone) && (op_q == OpRd)) ? mem_rdata : 16'h0000;
  assign Done    = (state_q == StDone);
  assign Stall   = (state_q == StBusy);
  assign Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders (LATENCY 1, 2, 4) share one request bus;
// each step checks the instance whose timing it targets.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd  = 1'b0;
  logic        wr  = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] din  = 16'h0000;

  logic [15:0] do1, do2, do4;
  logic        dn1, dn2, dn4;
  logic        st1, st2, st4;
  logic        er1, er2, er4;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .LATENCY(1), .ALIGN_CHK(1'b1)) u_l1 (
    .clk(clk), .rst(rst), .Rd(rd), .Wr(wr), .Addr(addr), .DataIn(din),
    .DataOut(do1), .Done(dn1), .Stall(st1), .Err(er1)
  );

  mem_responder #(.ADDR_W(10), .LATENCY(2), .ALIGN_CHK(1'b1)) u_l2 (
    .clk(clk), .rst(rst), .Rd(rd), .Wr(wr), .Addr(addr), .DataIn(din),
    .DataOut(do2), .Done(dn2), .Stall(st2), .Err(er2)
  );

  mem_responder #(.ADDR_W(10), .LATENCY(4), .ALIGN_CHK(1'b1)) u_l4 (
    .clk(clk), .rst(rst), .Rd(rd), .Wr(wr), .Addr(addr), .DataIn(din),
    .DataOut(do4), .Done(dn4), .Stall(st4), .Err(er4)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge; returns just after that edge.
  task automatic req(input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] d);
    rd   = r;
    wr   = w;
    addr = a;
    din  = d;
    cyc();
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic settle();
    repeat (5) cyc();
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_l2_dout", do2, 16'h0000);
    chk("rst_l2_done", {15'b0, dn2}, 16'h0000);
    chk("rst_l2_stall", {15'b0, st2}, 16'h0000);
    chk("rst_l2_err", {15'b0, er2}, 16'h0000);
    repeat (2) cyc();
    chk("rst_l4_stall", {15'b0, st4}, 16'h0000);
    rst = 1'b1;
    cyc();

    // L2 write 0x0010=BEEF: one Stall cycle then one Done cycle
    req(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("wr_l2_stall", {15'b0, st2}, 16'h0001);
    chk("wr_l2_nodone", {15'b0, dn2}, 16'h0000);
    chk("wr_l1_done", {15'b0, dn1}, 16'h0001);
    chk("wr_l1_nostall", {15'b0, st1}, 16'h0000);
    cyc();
    chk("wr_l2_done", {15'b0, dn2}, 16'h0001);
    chk("wr_l2_stall_off", {15'b0, st2}, 16'h0000);
    cyc();
    chk("wr_l2_done_off", {15'b0, dn2}, 16'h0000);
    chk("wr_l4_still_busy", {15'b0, st4}, 16'h0001);
    cyc();
    chk("wr_l4_done", {15'b0, dn4}, 16'h0001);
    settle();

    // Read back 0x0010
    req(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("rd_l1_done", {15'b0, dn1}, 16'h0001);
    chk("rd_l1_data", do1, 16'hBEEF);
    chk("rd_l1_nostall", {15'b0, st1}, 16'h0000);
    chk("rd_l2_stall", {15'b0, st2}, 16'h0001);
    cyc();
    chk("rd_l2_done", {15'b0, dn2}, 16'h0001);
    chk("rd_l2_data", do2, 16'hBEEF);
    settle();

    // Back-to-back: read presented during write's Done cycle
    req(1'b0, 1'b1, 16'h0020, 16'h1234);
    cyc();
    chk("b2b_wr_done", {15'b0, dn2}, 16'h0001);
    rd   = 1'b1;
    addr = 16'h0020;
    cyc();
    rd = 1'b0;
    chk("b2b_rd_stall", {15'b0, st2}, 16'h0001);
    chk("b2b_rd_nodone", {15'b0, dn2}, 16'h0000);
    cyc();
    chk("b2b_rd_done", {15'b0, dn2}, 16'h0001);
    chk("b2b_rd_data", do2, 16'h1234);
    settle();

    // Rd=Wr=1 reject leaves the array unchanged
    req(1'b0, 1'b1, 16'h0004, 16'h7777);
    settle();
    req(1'b1, 1'b1, 16'h0004, 16'h0000);
    chk("rej_both_err", {15'b0, er2}, 16'h0001);
    chk("rej_both_nostall", {15'b0, st2}, 16'h0000);
    chk("rej_both_nodone", {15'b0, dn2}, 16'h0000);
    cyc();
    chk("rej_both_err_off", {15'b0, er2}, 16'h0000);
    chk("rej_both_nodone2", {15'b0, dn2}, 16'h0000);
    req(1'b1, 1'b0, 16'h0004, 16'h0000);
    cyc();
    chk("rej_both_rd_done", {15'b0, dn2}, 16'h0001);
    chk("rej_both_rd_data", do2, 16'h7777);
    settle();

    // Misaligned read reject
    req(1'b1, 1'b0, 16'h0003, 16'h0000);
    chk("rej_align_err_l2", {15'b0, er2}, 16'h0001);
    chk("rej_align_err_l1", {15'b0, er1}, 16'h0001);
    chk("rej_align_nodone_l1", {15'b0, dn1}, 16'h0000);
    cyc();
    chk("rej_align_err_off", {15'b0, er2}, 16'h0000);
    chk("rej_align_nodone_l2", {15'b0, dn2}, 16'h0000);
    chk("rej_align_nostall", {15'b0, st2}, 16'h0000);
    settle();

    // Address alias: 0x0802 and 0x0002 hit the same word
    req(1'b0, 1'b1, 16'h0802, 16'h5555);
    settle();
    req(1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("alias_l1_data", do1, 16'h5555);
    cyc();
    chk("alias_l2_data", do2, 16'h5555);
    settle();

    // Reset abort of an L4 write during its 2nd BUSY cycle
    req(1'b0, 1'b1, 16'h0040, 16'h0000);
    settle();
    req(1'b0, 1'b1, 16'h0040, 16'hAAAA);
    cyc();
    chk("abort_l4_busy", {15'b0, st4}, 16'h0001);
    #3 rst = 1'b0;
    #1;
    chk("abort_l4_stall", {15'b0, st4}, 16'h0000);
    chk("abort_l4_done", {15'b0, dn4}, 16'h0000);
    chk("abort_l4_err", {15'b0, er4}, 16'h0000);
    chk("abort_l4_dout", do4, 16'h0000);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("abort_l4_no_done", {15'b0, dn4}, 16'h0000);
    end
    req(1'b1, 1'b0, 16'h0040, 16'h0000);
    cyc();
    cyc();
    chk("abort_rd_stall", {15'b0, st4}, 16'h0001);
    chk("abort_rd_nodone", {15'b0, dn4}, 16'h0000);
    cyc();
    chk("abort_rd_done", {15'b0, dn4}, 16'h0001);
    chk("abort_rd_data", do4, 16'h0000);
    chk("l1_never_stall", {15'b0, st1}, 16'h0000);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle data/instruction memory. It is the responder side of the pipeline's memory request interface.
- Accepts one word read or write request at a time from the fetch or memory stage. Completes it after a fixed, parameterised latency.
- Signals Stall while busy and pulses Done with read data on completion.
- Replaces the single-cycle memory behind the memory stage. The pipeline holds its request and its latches while Stall is high.

Parameters:
- ADDR_W, 10: word-address width. Array depth is 2^ADDR_W 16-bit words.
- LATENCY, 2: edges from request acceptance to the Done cycle. Legal range 1..15.
- ALIGN_CHK, 1: when 1, a request with Addr[0]=1 is rejected with Err.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- Rd  in  1  read request.
- Wr  in  1  write request.
- Addr  in  16  byte address. Word index is Addr[ADDR_W:1]; upper bits are ignored.
- DataIn  in  16  write data.
- DataOut  out  16  read data, valid only while Done=1.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  responder busy; requests are ignored while high.
- Err  out  1  one-cycle pulse flagging a rejected request.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; counter and captured address/data/op are cleared.
  - DataOut=0, Done=0, Stall=0, Err=0.
  - Array contents are not reset. An in-flight write is aborted and not committed.
- A request is valid when exactly one of Rd/Wr is 1 and it passes the alignment check.
- Rejected request (Rd=Wr=1, or ALIGN_CHK=1 and Addr[0]=1), sampled in IDLE or DONE:
  - Nothing is captured; the next state is IDLE.
  - Err=1 for exactly the following cycle; Done stays 0.
- FSM states IDLE, BUSY, DONE. Stall=1 only in BUSY; Done=1 only in DONE.
- IDLE:
  - Valid request at an edge: capture op, word index and DataIn; load counter with LATENCY-1.
  - Next state is BUSY if LATENCY>1, otherwise DONE.
- BUSY:
  - Counter decrements each edge. Leave for DONE on the edge where counter==1.
  - Total cycles in BUSY = LATENCY-1. Rd/Wr/Addr/DataIn are ignored.
- Edge entering DONE:
  - Write: array[word] <= captured data. DataOut holds its previous value (don't-care).
  - Read: DataOut <= array[word].
- DONE lasts exactly one cycle:
  - Done=1, Stall=0.
  - A new request present in this cycle is accepted at the next edge, using the same rules as IDLE, which gives back-to-back operation.
  - With no request, the next state is IDLE.
- Latency: for a request accepted at edge E0, Done is high in the cycle after edge E0+LATENCY-1. That is LATENCY cycles after the request cycle.
- Throughput: one request per LATENCY cycles.
- Read-after-write to the same word, back-to-back, returns the new data, because the write commits before the read is accepted.
- Reads and writes use a registered output only; DataOut never changes combinationally from Addr.
- Address wrap: addresses beyond the array alias modulo 2^ADDR_W words.
- Reset asserted mid-BUSY: the operation is dropped, no Done and no write. After reset deassertion, the block is in IDLE on the next edge.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - memory op encoding: OP_RD=1'b0, OP_WR=1'b1;
  - the default LATENCY.
- One natural sub-module: mem_array, a synchronous single-port 2^ADDR_W x 16 RAM with we, addr, wdata and registered rdata, and no reset.
- mem_responder holds the FSM, the latency counter, the request capture registers and the Err logic.

Test Plan:
- LATENCY=2, write Addr=0x0010 DataIn=0xBEEF:
  - Stall=1 for 1 cycle, then Done=1 for 1 cycle.
  - A subsequent read of 0x0010 gives Done with DataOut=0xBEEF, 2 cycles after acceptance.
- Back-to-back with the second request presented during DONE: write 0x0020=0x1234, then read 0x0020. The read returns 0x1234 with no idle cycle between the two Done pulses.
- Rejects:
  - Rd=Wr=1 at 0x0004 → Err=1 for one cycle, no Stall, no Done, array unchanged.
  - Rd at 0x0003 with ALIGN_CHK=1 → Err pulse, no Done.
- Reset abort:
  - LATENCY=4: write 0x0040=0xAAAA, pull rst low during the 2nd BUSY cycle.
  - All outputs read 0 immediately; a later read of 0x0040 returns the prior value (0x0000 after an initial write of 0), not 0xAAAA.
- Boundaries:
  - LATENCY=1: read → Done the cycle after acceptance, Stall never high.
  - ADDR_W=10: write 0x0802=0x5555, then read 0x0002 → 0x5555 (address alias).
